// File: rtl/if_stage.sv
// Instruction-fetch stage for the 5-stage RV32I pipeline.
// Holds the fetch PC and drives the instruction-memory address. Captures the
// returned word, together with its PC, into the IF/ID register. A redirect
// from EX flushes IF/ID and takes priority over a hazard-unit stall.
module if_stage #(
    parameter int               WIDTH    = 32,
    parameter int               IMEM_W   = 13,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int               CNT_W    = 32,
    parameter logic [WIDTH-1:0] NOP      = 32'h0000_0013
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [WIDTH-1:0]  redirect_pc_i,
    output logic [IMEM_W-1:0] imem_addr_o,
    input  logic [WIDTH-1:0]  imem_data_i,
    output logic [WIDTH-1:0]  pc_o,
    output logic [WIDTH-1:0]  if_id_pc_o,
    output logic [WIDTH-1:0]  if_id_instr_o,
    output logic              if_id_valid_o,
    output logic              misalign_o,
    output logic [CNT_W-1:0]  fetch_cnt_o
);

    logic [WIDTH-1:0] pc_reg,          pc_next;
    logic [WIDTH-1:0] if_id_pc_reg,    if_id_pc_next;
    logic [WIDTH-1:0] if_id_instr_reg, if_id_instr_next;
    logic             if_id_valid_reg, if_id_valid_next;
    logic             misalign_reg,    misalign_next;
    logic [CNT_W-1:0] fetch_cnt_reg,   fetch_cnt_next;

    // Memory address is the low PC bits only, so the PC aliases within memory.
    generate
        for (genvar gi = 0; gi < IMEM_W; gi++) begin : g_imem_addr
            assign imem_addr_o[gi] = pc_reg[gi];
        end
    endgenerate

    // Next-state selection: redirect beats stall, stall beats advance.
    always_comb begin
        pc_next          = pc_reg;
        if_id_pc_next    = if_id_pc_reg;
        if_id_instr_next = if_id_instr_reg;
        if_id_valid_next = if_id_valid_reg;
        fetch_cnt_next   = fetch_cnt_reg;
        misalign_next    = 1'b0;
        if (redirect_i) begin
            // The word in IF/ID is wrong-path; replace it with a bubble and
            // fetch from the word-aligned target.
            pc_next          = {redirect_pc_i[WIDTH-1:2], 2'b00};
            if_id_pc_next    = '0;
            if_id_instr_next = NOP;
            if_id_valid_next = 1'b0;
            misalign_next    = |redirect_pc_i[1:0];
        end else if (!stall_i) begin
            pc_next          = pc_reg + WIDTH'(4);
            if_id_pc_next    = pc_reg;
            if_id_instr_next = imem_data_i;
            if_id_valid_next = 1'b1;
            if (fetch_cnt_reg != {CNT_W{1'b1}}) begin
                fetch_cnt_next = fetch_cnt_reg + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous active-low reset dominating everything.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_reg          <= RESET_PC;
            if_id_pc_reg    <= '0;
            if_id_instr_reg <= NOP;
            if_id_valid_reg <= 1'b0;
            misalign_reg    <= 1'b0;
            fetch_cnt_reg   <= '0;
        end else begin
            pc_reg          <= pc_next;
            if_id_pc_reg    <= if_id_pc_next;
            if_id_instr_reg <= if_id_instr_next;
            if_id_valid_reg <= if_id_valid_next;
            misalign_reg    <= misalign_next;
            fetch_cnt_reg   <= fetch_cnt_next;
        end
    end

    assign pc_o          = pc_reg;
    assign if_id_pc_o    = if_id_pc_reg;
    assign if_id_instr_o = if_id_instr_reg;
    assign if_id_valid_o = if_id_valid_reg;
    assign misalign_o    = misalign_reg;
    assign fetch_cnt_o   = fetch_cnt_reg;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios followed by random stall,
// redirect and reset traffic, all checked against a cycle-level model.
module tb_if_stage;

    localparam int          WIDTH  = 32;
    localparam int          IMEM_W = 13;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              stall = 1'b0;
    logic              redirect = 1'b0;
    logic [WIDTH-1:0]  redirect_pc = '0;
    logic [IMEM_W-1:0] imem_addr;
    logic [WIDTH-1:0]  imem_data;
    logic [WIDTH-1:0]  pc;
    logic [WIDTH-1:0]  if_id_pc;
    logic [WIDTH-1:0]  if_id_instr;
    logic              if_id_valid;
    logic              misalign;
    logic [CNT_W-1:0]  fetch_cnt;

    // 8 KB instruction memory as 2048 words, zero read latency.
    logic [31:0] mem [0:2047];
    assign imem_data = mem[imem_addr[12:2]];

    // Reference state, updated from the behavioural rules each edge.
    logic [31:0] m_pc, m_ifpc, m_instr;
    logic        m_valid, m_mis;
    int          m_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_cycle  = 0;

    if_stage #(
        .WIDTH(WIDTH), .IMEM_W(IMEM_W), .RESET_PC(RST_PC),
        .CNT_W(CNT_W), .NOP(NOP)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .imem_addr_o(imem_addr), .imem_data_i(imem_data),
        .pc_o(pc), .if_id_pc_o(if_id_pc), .if_id_instr_o(if_id_instr),
        .if_id_valid_o(if_id_valid), .misalign_o(misalign),
        .fetch_cnt_o(fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL cycle %0d %s: got %h expected %h", n_cycle, tag, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic cycle(input logic r_n, input logic st, input logic rd, input logic [31:0] rpc);
        rst_n       = r_n;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        if (!r_n) begin
            m_pc = RST_PC; m_ifpc = 0; m_instr = NOP; m_valid = 0; m_mis = 0; m_cnt = 0;
        end else if (rd) begin
            m_pc    = rpc & ~32'h3;
            m_ifpc  = 0;
            m_instr = NOP;
            m_valid = 0;
            m_mis   = (rpc % 4) != 0;
        end else if (st) begin
            m_mis = 0;
        end else begin
            m_ifpc  = m_pc;
            m_instr = mem[(m_pc % 8192) / 4];
            m_valid = 1;
            m_pc    = m_pc + 4;
            m_mis   = 0;
            m_cnt   = (m_cnt >= 15) ? 15 : m_cnt + 1;
        end
        @(posedge clk);
        #1;
        n_cycle++;
        chk("pc",        pc,                 m_pc);
        chk("imem_addr", {19'd0, imem_addr}, m_pc % 8192);
        chk("if_id_pc",  if_id_pc,           m_ifpc);
        chk("if_id_ins", if_id_instr,        m_instr);
        chk("if_id_vld", {31'd0, if_id_valid}, {31'd0, m_valid});
        chk("misalign",  {31'd0, misalign},  {31'd0, m_mis});
        chk("fetch_cnt", {28'd0, fetch_cnt}, m_cnt);
        $display("cyc %0d rst_n=%0b st=%0b rd=%0b rpc=%h | pc=%h ifid=(%h,%h,%0b) mis=%0b cnt=%0d",
                 n_cycle, r_n, st, rd, rpc, pc, if_id_pc, if_id_instr, if_id_valid, misalign, fetch_cnt);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = $urandom;
        m_pc = RST_PC; m_ifpc = 0; m_instr = NOP; m_valid = 0; m_mis = 0; m_cnt = 0;
        @(negedge clk);

        // Reset held two cycles, then sequential fetch.
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("rst_pc",    pc, RST_PC);
        chk("rst_instr", if_id_instr, NOP);
        cycle(1, 0, 0, 0);
        chk("seq_ifid0", if_id_instr, mem[0]);
        cycle(1, 0, 0, 0);
        chk("seq_pc8", pc, 32'h8);

        // Stall three cycles at pc 0x8, then release.
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
        chk("stall_ifid", if_id_instr, mem[1]);
        cycle(1, 0, 0, 0);
        chk("unstall_ifid", if_id_instr, mem[2]);

        // Redirect while stalled, then target instruction.
        cycle(1, 1, 1, 32'h40);
        chk("redir_pc", pc, 32'h40);
        cycle(1, 0, 0, 0);
        chk("redir_ifid", if_id_instr, mem[16]);

        // Misaligned redirect pulses misalign for one cycle.
        cycle(1, 0, 1, 32'h46);
        chk("mis_pulse", {31'd0, misalign}, 32'd1);
        cycle(1, 0, 0, 0);
        chk("mis_clear", {31'd0, misalign}, 32'd0);

        // Aliasing across the top of memory.
        cycle(1, 0, 1, 32'h0000_3FFC);
        cycle(1, 0, 0, 0);
        chk("alias_addr", {19'd0, imem_addr}, 32'h0);
        cycle(1, 0, 0, 0);

        // Counter saturation then a single reset edge.
        for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0);
        chk("cnt_sat", {28'd0, fetch_cnt}, 32'd15);
        cycle(0, 1, 1, 32'h80);
        chk("rst_cnt", {28'd0, fetch_cnt}, 32'd0);

        // Redirect on the edge reset is still asserted is ignored.
        cycle(0, 0, 1, 32'h100);
        for (int i = 0; i < 1500; i++) begin
            logic        r_n, st, rd;
            logic [31:0] rpc;
            r_n = ($urandom_range(0, 63) != 0);
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 7) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 1) == 0) rpc = rpc & 32'h0000_1FFF;
            cycle(r_n, st, rd, rpc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
